// File: rtl/uart_transmit.sv
// uart_transmit: 8N1 UART transmitter with a valid/ready byte input and a
// one-byte holding register, so that consecutive frames leave with no idle gap.
// Optional even parity bit between the data bits and the stop bit(s) is
// enabled by defining UART_TX_PARITY_EN.
module uart_transmit #(
  parameter int INPUT_CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE        = 9600,
  parameter int STOP_BITS        = 1
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       data_valid_in,
  input  logic [7:0] data_byte_in,
  output logic       data_ready_out,
  output logic       tx_wire_out,
  output logic       busy_out,
  output logic       done_out
);

  // Rounded-up bit period, matching the receiver's arithmetic.
  localparam int BAUD_BIT_PERIOD = (INPUT_CLOCK_FREQ + BAUD_RATE - 1) / BAUD_RATE;
  localparam int CNT_W = (BAUD_BIT_PERIOD > 1) ? $clog2(BAUD_BIT_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_BIT_PERIOD - 1);
  localparam logic STOP_LAST = (STOP_BITS == 2);

  // Only one or two stop bits are meaningful.
  generate
    if (!(STOP_BITS == 1 || STOP_BITS == 2)) begin : g_bad_stop_bits
      $error("uart_transmit: STOP_BITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
    , S_PARITY = 3'd4
`endif
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] baud_cnt_reg, baud_cnt_next;
  logic [2:0]       bit_cnt_reg, bit_cnt_next;
  logic             stop_cnt_reg, stop_cnt_next;
  logic [7:0]       shift_reg, shift_next;
  logic [7:0]       hold_reg, hold_next;
  logic             hold_full_reg, hold_full_next;
  logic             tx_reg, tx_next;
  logic             ready_reg, ready_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
`ifdef UART_TX_PARITY_EN
  logic             parity_reg, parity_next;
  logic             load_parity;
`endif

  logic       xfer;
  logic       baud_tick;
  logic       frame_end;
  logic [7:0] load_byte;

  assign xfer      = data_valid_in && ready_reg;
  assign baud_tick = (baud_cnt_reg == CNT_LAST);
  assign frame_end = (state_reg == S_STOP) && baud_tick && (stop_cnt_reg == STOP_LAST);
  // A waiting held byte always wins over a byte offered on the same edge.
  assign load_byte = hold_full_reg ? hold_reg : data_byte_in;
`ifdef UART_TX_PARITY_EN
  assign load_parity = ^load_byte;
`endif

  // State register plus registered outputs; reset forces the line high at once.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg     <= S_IDLE;
      baud_cnt_reg  <= '0;
      bit_cnt_reg   <= '0;
      stop_cnt_reg  <= 1'b0;
      shift_reg     <= '0;
      hold_reg      <= '0;
      hold_full_reg <= 1'b0;
      tx_reg        <= 1'b1;
      ready_reg     <= 1'b1;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_reg    <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      baud_cnt_reg  <= baud_cnt_next;
      bit_cnt_reg   <= bit_cnt_next;
      stop_cnt_reg  <= stop_cnt_next;
      shift_reg     <= shift_next;
      hold_reg      <= hold_next;
      hold_full_reg <= hold_full_next;
      tx_reg        <= tx_next;
      ready_reg     <= ready_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
`ifdef UART_TX_PARITY_EN
      parity_reg    <= parity_next;
`endif
    end
  end

  // Next-state logic: frame sequencing, baud/bit counters and the holding register.
  always_comb begin
    state_next     = state_reg;
    baud_cnt_next  = baud_cnt_reg;
    bit_cnt_next   = bit_cnt_reg;
    stop_cnt_next  = stop_cnt_reg;
    shift_next     = shift_reg;
    hold_next      = hold_reg;
    hold_full_next = hold_full_reg;
`ifdef UART_TX_PARITY_EN
    parity_next    = parity_reg;
`endif

    if (state_reg != S_IDLE) begin
      baud_cnt_next = baud_tick ? '0 : baud_cnt_reg + CNT_W'(1);
    end

    // Byte accepted while a frame runs (and not taken directly at frame end) is parked.
    if (xfer && (state_reg != S_IDLE) && !frame_end) begin
      hold_next      = data_byte_in;
      hold_full_next = 1'b1;
    end

    case (state_reg)
      S_IDLE: begin
        if (xfer) begin
          shift_next    = data_byte_in;
`ifdef UART_TX_PARITY_EN
          parity_next   = load_parity;
`endif
          baud_cnt_next = '0;
          state_next    = S_START;
        end
      end
      S_START: begin
        if (baud_tick) begin
          bit_cnt_next = '0;
          state_next   = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          shift_next = {1'b0, shift_reg[7:1]};
          if (bit_cnt_reg == 3'd7) begin
            stop_cnt_next = 1'b0;
`ifdef UART_TX_PARITY_EN
            state_next    = S_PARITY;
`else
            state_next    = S_STOP;
`endif
          end else begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_tick) begin
          stop_cnt_next = 1'b0;
          state_next    = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (baud_tick) begin
          if (stop_cnt_reg == STOP_LAST) begin
            if (hold_full_reg || xfer) begin
              shift_next     = load_byte;
`ifdef UART_TX_PARITY_EN
              parity_next    = load_parity;
`endif
              hold_full_next = 1'b0;
              state_next     = S_START;
            end else begin
              state_next = S_IDLE;
            end
          end else begin
            stop_cnt_next = 1'b1;
          end
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Output logic: derive next registered outputs from next-state values.
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      S_START:  tx_next = 1'b0;
      S_DATA:   tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_next = parity_next;
`endif
      default:  tx_next = 1'b1;
    endcase
    busy_next  = (state_next != S_IDLE);
    ready_next = !hold_full_next;
    done_next  = (state_next == S_STOP) && (baud_cnt_next == CNT_LAST) &&
                 (stop_cnt_next == STOP_LAST);
  end

  assign data_ready_out = ready_reg;
  assign tx_wire_out    = tx_reg;
  assign busy_out       = busy_reg;
  assign done_out       = done_reg;

endmodule

// File: tb/tb_uart_transmit.sv
// tb_uart_transmit: directed bench for uart_transmit at 10 clocks per bit.
// Instance dut uses one stop bit, dut2 two stop bits. A small serial
// receiver model decodes dut's line to confirm byte order and count.
module tb_uart_transmit;
  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int P      = 10;
`ifdef UART_TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int F1 = (9 + PAR_BITS + 1) * P;
  localparam int F2 = (9 + PAR_BITS + 2) * P;
  localparam int STOP_SAMPLE = 95 + PAR_BITS * P;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b0;
  logic       v1 = 1'b0, v2 = 1'b0;
  logic [7:0] d1 = 8'h00, d2 = 8'h00;
  logic       rdy1, tx1, busy1, done1;
  logic       rdy2, tx2, busy2, done2;

  always #5 clk_in = ~clk_in;

  uart_transmit #(.INPUT_CLOCK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .STOP_BITS(1)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .data_valid_in(v1), .data_byte_in(d1),
    .data_ready_out(rdy1), .tx_wire_out(tx1), .busy_out(busy1), .done_out(done1));

  uart_transmit #(.INPUT_CLOCK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .STOP_BITS(2)) dut2 (
    .clk_in(clk_in), .rst_in(rst_in), .data_valid_in(v2), .data_byte_in(d2),
    .data_ready_out(rdy2), .tx_wire_out(tx2), .busy_out(busy2), .done_out(done2));

  int checks = 0;
  int errors = 0;

  // Receiver model for dut's line: mid-bit sampling, pushes each decoded byte.
  logic [7:0] rx_q[$];
  logic [7:0] rx_sh = 8'h00;
  logic       rx_active = 1'b0;
  int         rx_cnt = 0;
  int         rx_err = 0;
  int         done_cnt = 0;

  always @(posedge clk_in) begin
    if (done1 === 1'b1) done_cnt <= done_cnt + 1;
    if (rst_in) begin
      rx_active <= 1'b0;
    end else if (!rx_active) begin
      if (tx1 === 1'b0) begin
        rx_active <= 1'b1;
        rx_cnt    <= 1;
      end
    end else begin
      rx_cnt <= rx_cnt + 1;
      if (rx_cnt >= 15 && rx_cnt <= 85 && (rx_cnt % 10) == 5) rx_sh <= {tx1, rx_sh[7:1]};
      if (PAR_BITS == 1 && rx_cnt == 95 && tx1 !== ^rx_sh) rx_err <= rx_err + 1;
      if (rx_cnt == STOP_SAMPLE) begin
        rx_active <= 1'b0;
        if (tx1 === 1'b1) rx_q.push_back(rx_sh);
        else rx_err <= rx_err + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  // Expected line level at cycle k (1-based) of a frame carrying b.
  function automatic logic exp_tx(input logic [7:0] b, input int k);
    int bi;
    bi = (k - 1) / P;
    if (bi == 0) return 1'b0;
    if (bi <= 8) return b[bi-1];
    if (PAR_BITS == 1 && bi == 9) return ^b;
    return 1'b1;
  endfunction

  // Check line, done and busy on frame cycles k0..k1, advancing one clock each.
  task automatic check_range(input logic [7:0] b, input int k0, input int k1,
                             input int nstop, input bit sel);
    int frame;
    frame = (9 + PAR_BITS + nstop) * P;
    for (int k = k0; k <= k1; k++) begin
      logic t, dn, bs;
      t  = sel ? tx2 : tx1;
      dn = sel ? done2 : done1;
      bs = sel ? busy2 : busy1;
      chk($sformatf("tx b=%02h k=%0d", b, k), t, exp_tx(b, k));
      chk($sformatf("done b=%02h k=%0d", b, k), dn, (k == frame));
      chk($sformatf("busy b=%02h k=%0d", b, k), bs, 1'b1);
      tick;
    end
  endtask

  task automatic send1(input logic [7:0] b);
    chk("ready before send", rdy1, 1'b1);
    d1 = b;
    v1 = 1'b1;
    tick;
    v1 = 1'b0;
    $display("[%0t] send byte %02h", $time, b);
  endtask

  initial begin
    int n, base, qsz;

    // Reset state
    rst_in = 1'b1;
    #1;
    chk("reset tx", tx1, 1'b1);
    chk("reset ready", rdy1, 1'b1);
    chk("reset busy", busy1, 1'b0);
    chk("reset done", done1, 1'b0);
    tick; tick;
    rst_in = 1'b0;
    tick;
    chk("idle tx", tx1, 1'b1);

    // Single byte 0xA5
    send1(8'hA5);
    check_range(8'hA5, 1, F1, 1, 0);
    chk("A5 busy after", busy1, 1'b0);
    chk("A5 tx after", tx1, 1'b1);
    chk("A5 ready after", rdy1, 1'b1);

    // Back-to-back 0x00 then 0xFF, second offered mid-frame
    send1(8'h00);
    check_range(8'h00, 1, 20, 1, 0);
    chk("b2b ready at offer", rdy1, 1'b1);
    d1 = 8'hFF;
    v1 = 1'b1;
    check_range(8'h00, 21, 21, 1, 0);
    v1 = 1'b0;
    $display("[%0t] queued byte ff", $time);
    chk("b2b ready held low", rdy1, 1'b0);
    check_range(8'h00, 22, F1 - 1, 1, 0);
    chk("b2b ready still low", rdy1, 1'b0);
    check_range(8'h00, F1, F1, 1, 0);
    chk("b2b ready after end", rdy1, 1'b1);
    check_range(8'hFF, 1, F1, 1, 0);
    chk("b2b busy after", busy1, 1'b0);
    chk("rx count 3", rx_q.size(), 3);
    if (rx_q.size() == 3) begin
      chk("rx byte0", rx_q[0], 8'hA5);
      chk("rx byte1", rx_q[1], 8'h00);
      chk("rx byte2", rx_q[2], 8'hFF);
    end
    rx_q.delete();

    // Three bytes with data_valid_in held high
    base = done_cnt;
    d1 = 8'h11;
    v1 = 1'b1;
    tick;
    d1 = 8'h22;
    chk("three ready c1", rdy1, 1'b1);
    tick;
    d1 = 8'h33;
    chk("three stall ready", rdy1, 1'b0);
    n = 0;
    while (!rdy1 && n < 300) begin
      tick;
      n++;
    end
    chk("three stall cycles", n, F1 - 1);
    tick;
    v1 = 1'b0;
    $display("[%0t] offered bytes 11 22 33", $time);
    n = 0;
    while (done_cnt < base + 3 && n < 1000) begin
      tick;
      n++;
    end
    chk("three done pulses", done_cnt - base, 3);
    tick;
    chk("three idle", busy1, 1'b0);
    chk("three rx count", rx_q.size(), 3);
    if (rx_q.size() == 3) begin
      chk("three rx0", rx_q[0], 8'h11);
      chk("three rx1", rx_q[1], 8'h22);
      chk("three rx2", rx_q[2], 8'h33);
    end
    rx_q.delete();

    // Reset during DATA bit 3 of 0x0F
    send1(8'h0F);
    check_range(8'h0F, 1, 44, 1, 0);
    chk("0F D3 level", tx1, 1'b1);
    base = done_cnt;
    qsz = rx_q.size();
    rst_in = 1'b1;
    #1;
    chk("midrst tx", tx1, 1'b1);
    chk("midrst busy", busy1, 1'b0);
    chk("midrst ready", rdy1, 1'b1);
    chk("midrst done", done1, 1'b0);
    tick; tick;
    rst_in = 1'b0;
    $display("[%0t] reset pulse during byte 0f", $time);
    tick;
    chk("postrst tx", tx1, 1'b1);
    chk("postrst no done", done_cnt, base);
    chk("postrst no rx", rx_q.size(), qsz);
    send1(8'h3C);
    check_range(8'h3C, 1, F1, 1, 0);
    chk("postrst rx count", rx_q.size(), qsz + 1);
    if (rx_q.size() == qsz + 1) chk("postrst rx byte", rx_q[qsz], 8'h3C);

    // Two stop bits, 0x55
    chk("dut2 ready", rdy2, 1'b1);
    d2 = 8'h55;
    v2 = 1'b1;
    tick;
    v2 = 1'b0;
    $display("[%0t] send byte 55 (two stop bits)", $time);
    check_range(8'h55, 1, F2, 2, 1);
    chk("dut2 busy after", busy2, 1'b0);
    chk("dut2 tx after", tx2, 1'b1);

`ifdef UART_TX_PARITY_EN
    // Parity bit: 0x07 -> 1, 0x03 -> 0
    send1(8'h07);
    check_range(8'h07, 1, 94, 1, 0);
    chk("parity 07", tx1, 1'b1);
    check_range(8'h07, 95, F1, 1, 0);
    send1(8'h03);
    check_range(8'h03, 1, 94, 1, 0);
    chk("parity 03", tx1, 1'b0);
    check_range(8'h03, 95, F1, 1, 0);
`endif

    tick;
    chk("rx framing errors", rx_err, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_transmit.md
Name: uart_transmit

Overview:
- UART transmitter: serialises bytes onto a single wire as 8N1 frames (start bit, 8 data bits LSB-first, stop bit(s)).
- Companion to the design's UART receiver, using the same baud period arithmetic.
- Accepts bytes through a valid/ready handshake.
- A one-byte holding register lets frames go out back-to-back with no idle gap.

Parameters:
- INPUT_CLOCK_FREQ, 100_000_000: clock frequency in Hz.
- BAUD_RATE, 9600: line rate in bits per second.
- STOP_BITS, 1: number of stop bits; legal values are 1 or 2; any other value is a compile-time error.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous, active-high reset
- data_valid_in  input  1  byte on data_byte_in is offered
- data_byte_in  input  8  byte to transmit
- data_ready_out  output  1  block can accept a byte this cycle
- tx_wire_out  output  1  serial line, idles high
- busy_out  output  1  a frame is in progress (state is not IDLE)
- done_out  output  1  one-cycle pulse at completion of each frame

Behaviour:
- Baud timing:
  - BAUD_BIT_PERIOD = (INPUT_CLOCK_FREQ + BAUD_RATE - 1) / BAUD_RATE.
  - Counter width is $clog2(BAUD_BIT_PERIOD).
  - Counter counts 0 to BAUD_BIT_PERIOD-1; each bit is held exactly BAUD_BIT_PERIOD cycles.
- Reset (asynchronous, clears immediately):
  - tx_wire_out=1, data_ready_out=1, busy_out=0, done_out=0.
  - State IDLE; holding register empty; counters 0.
  - Reset mid-frame aborts the frame; the line returns high with no glitch low.
- Handshake:
  - Transfer occurs on the rising edge where data_valid_in && data_ready_out.
  - data_ready_out = holding register empty; it is registered.
  - data_byte_in is sampled only on a transfer.
- States:
  - IDLE: tx=1. On transfer, load the shift register directly (holding register stays empty) and go to START. tx goes low on the cycle after the transfer edge.
  - START: tx=0 for one period, then DATA.
  - DATA: tx = shift[0]; shift right once per period; bit counter 0..7. After 8 periods go to STOP (or PARITY when the optional feature is enabled).
  - STOP: tx=1 for STOP_BITS periods.
- End of STOP (last cycle of the last stop period):
  - done_out=1 for exactly that one cycle.
  - Next source, in priority order:
    1. Holding register full: load it into the shift register, empty it, go to START.
    2. Holding register empty and a transfer occurs this same edge: load data_byte_in directly, go to START.
    3. Otherwise: go to IDLE.
  - Cases 1 and 2 give a contiguous next frame: start bit begins the very next cycle, zero idle cycles.
- Transfer during START/DATA/STOP (other than the STOP-end edge): byte goes into the holding register; data_ready_out falls the next cycle.
- Back-pressure: with a frame active and the holding register full, data_ready_out=0. Offered bytes are neither lost nor duplicated.
- busy_out=1 in START, DATA, PARITY and STOP.
- All outputs are registered; tx_wire_out has no combinational path from inputs.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP for one period.
  - tx = XOR of the 8 data bits (even parity).
  - Parity is computed from the byte at load time and stored in a flop.
  - Frame length is 10+STOP_BITS periods.
- Undefined: no parity state or logic; frame length is 9+STOP_BITS periods.

Test Plan (bench uses INPUT_CLOCK_FREQ=1_000_000, BAUD_RATE=100_000, so period = 10 cycles):
- Single byte 0xA5 offered in IDLE:
  - tx low from cycle T+1 for 10 cycles.
  - Then bits 1,0,1,0,0,1,0,1, each 10 cycles.
  - Then high 10 cycles.
  - done_out pulses once at cycle T+100; busy_out falls the next cycle.
- Back-to-back 0x00 then 0xFF, second offered mid-frame:
  - data_ready_out low until the first frame ends.
  - Second start bit immediately follows the first stop bit (0 idle cycles).
  - Two done_out pulses 100 cycles apart.
- Three bytes with data_valid_in held high:
  - Third byte stalls while the holding register is full.
  - All three appear on the wire in order; none lost or duplicated.
- rst_in asserted during DATA bit 3 of 0x0F:
  - tx_wire_out=1, busy_out=0, data_ready_out=1 immediately.
  - No done_out pulse.
  - A new byte after reset transmits correctly.
- STOP_BITS=2, byte 0x55: stop high lasts 20 cycles; frame 110 cycles.
- UART_TX_PARITY_EN defined:
  - 0x07 gives parity bit 1 after D7; 0x03 gives 0.
  - Frame 110 cycles; done_out timing shifts accordingly.
